fpa_reduce_sched: RTL and testbench

- Scheduler that reduces a vector of N floating-point operands to one value using a single shared FP add unit.
- The add unit is external, fully pipelined, has no back-pressure and returns each result a fixed number of cycles after issue.
- The block loads operands over a valid/ready stream and keeps pending values in a circular buffer. It issues a pair to the add unit whenever two values are available and writes returned results back into the buffer.
- It presents the final sum plus sticky overflow/underflow/exception flags on a valid/ready output.

---
 rtl/fpa_reduce_sched_if.sv | 46 ++++
 rtl/fpa_reduce_sched.sv | 135 +++++++++++++
 tb/tb_fpa_reduce_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpa_reduce_sched_if.sv
// Handshake and add-unit bus for the FP reduction scheduler.
// The slave modport is the scheduler side; master is the environment side.
interface fpa_reduce_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  iEN;
    logic                  iSTART;
    logic [1:0]            iFPA_OPERATION;
    logic                  iIN_VALID;
    logic [DATA_WIDTH-1:0] iIN_DATA;
    logic                  oIN_READY;
    logic                  oADD_VALID;
    logic [DATA_WIDTH-1:0] oADD_A;
    logic [DATA_WIDTH-1:0] oADD_B;
    logic [1:0]            oADD_OPERATION;
    logic                  iADD_VALID;
    logic [DATA_WIDTH-1:0] iADD_RESULT;
    logic                  iADD_OVERFLOW;
    logic                  iADD_UNDERFLOW;
    logic                  iADD_EXCEPTION;
    logic                  oOUT_VALID;
    logic                  iOUT_READY;
    logic [DATA_WIDTH-1:0] oFPA_RESULT;
    logic                  oFPA_OVERFLOW;
    logic                  oFPA_UNDERFLOW;
    logic                  oFPA_EXCEPTION;
    logic                  oBUSY;

    modport slave (
        input  iEN, iSTART, iFPA_OPERATION, iIN_VALID, iIN_DATA,
               iADD_VALID, iADD_RESULT, iADD_OVERFLOW, iADD_UNDERFLOW, iADD_EXCEPTION,
               iOUT_READY,
        output oIN_READY, oADD_VALID, oADD_A, oADD_B, oADD_OPERATION,
               oOUT_VALID, oFPA_RESULT, oFPA_OVERFLOW, oFPA_UNDERFLOW, oFPA_EXCEPTION,
               oBUSY
    );

    modport master (
        output iEN, iSTART, iFPA_OPERATION, iIN_VALID, iIN_DATA,
               iADD_VALID, iADD_RESULT, iADD_OVERFLOW, iADD_UNDERFLOW, iADD_EXCEPTION,
               iOUT_READY,
        input  oIN_READY, oADD_VALID, oADD_A, oADD_B, oADD_OPERATION,
               oOUT_VALID, oFPA_RESULT, oFPA_OVERFLOW, oFPA_UNDERFLOW, oFPA_EXCEPTION,
               oBUSY
    );
endinterface

// File: rtl/fpa_reduce_sched.sv
// Reduces N FP operands to one sum through a single shared, fully pipelined
// external adder, keeping pending values in a circular buffer in arrival order.
module fpa_reduce_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 16,
    parameter int CW         = $clog2(N + 1)
) (
    input logic iCLK,
    input logic iNRESET,
    fpa_reduce_sched_if.slave bus
);
    localparam int PW    = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 1 << PW;

    typedef enum logic [1:0] {IDLE, LOAD, REDUCE, DONE} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr1, rd_ptr2;
    logic [CW-1:0]         count, loaded, issued, completed;
    logic [1:0]            op_q;
    logic                  sticky_ovf, sticky_unf, sticky_exc;
    logic                  add_valid_q;
    logic [DATA_WIDTH-1:0] add_a_q, add_b_q;
    logic                  start, accept_in, accept_ret, issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_ptr1 = ptr_inc(rd_ptr);
    assign rd_ptr2 = ptr_inc(rd_ptr1);

    // Returns are only absorbed while some issue is still outstanding, so
    // stale results from an abandoned job can never be mistaken for new ones.
    assign start      = (state == IDLE) && bus.iSTART;
    assign accept_in  = (state == LOAD) && bus.iIN_VALID;
    assign accept_ret = (state == REDUCE) && bus.iADD_VALID && (completed != issued);
    assign issue      = (state == REDUCE) && bus.iEN && (count >= CW'(2))
                        && (issued < CW'(N - 1));

    always_ff @(posedge iCLK or negedge iNRESET) begin
        if (!iNRESET) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.iSTART) state_next = LOAD;
            LOAD:    if (accept_in && (loaded == CW'(N - 1)))
                         state_next = (N == 1) ? DONE : REDUCE;
            REDUCE:  if (accept_ret && (completed == CW'(N - 2))) state_next = DONE;
            DONE:    if (bus.iOUT_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.oIN_READY      = (state == LOAD);
        bus.oOUT_VALID     = (state == DONE);
        bus.oBUSY          = (state != IDLE);
        bus.oADD_VALID     = add_valid_q;
        bus.oADD_A         = add_a_q;
        bus.oADD_B         = add_b_q;
        bus.oADD_OPERATION = op_q;
        bus.oFPA_RESULT    = '0;
        bus.oFPA_OVERFLOW  = 1'b0;
        bus.oFPA_UNDERFLOW = 1'b0;
        bus.oFPA_EXCEPTION = 1'b0;
        if (state == DONE) begin
            bus.oFPA_RESULT    = mem[rd_ptr];
            bus.oFPA_OVERFLOW  = sticky_ovf;
            bus.oFPA_UNDERFLOW = sticky_unf;
            bus.oFPA_EXCEPTION = sticky_exc;
        end
    end

    always_ff @(posedge iCLK or negedge iNRESET) begin
        if (!iNRESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            loaded      <= '0;
            issued      <= '0;
            completed   <= '0;
            op_q        <= '0;
            sticky_ovf  <= 1'b0;
            sticky_unf  <= 1'b0;
            sticky_exc  <= 1'b0;
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            add_valid_q <= issue;
            if (start) begin
                op_q       <= bus.iFPA_OPERATION;
                sticky_ovf <= 1'b0;
                sticky_unf <= 1'b0;
                sticky_exc <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                loaded     <= '0;
                issued     <= '0;
                completed  <= '0;
            end else begin
                count <= count + CW'(accept_in || accept_ret) - (issue ? CW'(2) : CW'(0));
            end
            if (issue) begin
                add_a_q <= mem[rd_ptr];
                add_b_q <= mem[rd_ptr1];
                rd_ptr  <= rd_ptr2;
                issued  <= issued + 1'b1;
            end
            if (accept_in) begin
                wr_ptr <= ptr_inc(wr_ptr);
                loaded <= loaded + 1'b1;
            end
            if (accept_ret) begin
                wr_ptr     <= ptr_inc(wr_ptr);
                completed  <= completed + 1'b1;
                sticky_ovf <= sticky_ovf | bus.iADD_OVERFLOW;
                sticky_unf <= sticky_unf | bus.iADD_UNDERFLOW;
                sticky_exc <= sticky_exc | bus.iADD_EXCEPTION;
            end
        end
    end

    // Loads and returns occur in different states, so one write port suffices.
    always_ff @(posedge iCLK) begin
        if (accept_in)       mem[wr_ptr] <= bus.iIN_DATA;
        else if (accept_ret) mem[wr_ptr] <= bus.iADD_RESULT;
    end
endmodule

// File: tb/tb_fpa_reduce_sched.sv
// Scoreboard bench for fpa_reduce_sched: three instances (N=4, N=1, N=16)
// share stimulus, each with a latency-2 add-unit model.
module tb_fpa_reduce_sched;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, start, in_valid, out_ready, ovf_inject, en_toggle;
    logic [1:0]  op, sel;
    logic [31:0] in_data;
    logic [31:0] ops [16];

    logic        in_ready_v [3], add_valid_v [3], out_valid_v [3], busy_v [3];
    logic        ovf_v [3], unf_v [3], exc_v [3];
    logic [31:0] add_a_v [3], add_b_v [3], res_v [3];
    logic [1:0]  add_op_v [3];

    logic        sel_in_ready, sel_add_valid, sel_out_valid, sel_busy;
    logic        sel_ovf, sel_unf, sel_exc;
    logic [31:0] sel_add_a, sel_add_b, sel_res;
    logic [1:0]  sel_add_op;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int max_count = 0;

    logic [31:0] exp_a_q [$];
    logic [31:0] exp_b_q [$];
    logic [31:0] exp_res_q [$];
    logic [2:0]  exp_flag_q [$];

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        e = {3'b000, f[30:23]} + 11'd896;
        if (f[30:0] == 31'd0) return 0.0;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int NN = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        fpa_reduce_sched_if #(.DATA_WIDTH(DW)) bus ();
        logic        s1_v = 1'b0, s2_v = 1'b0;
        logic [31:0] s1_r = 32'd0, s2_r = 32'd0;
        int          rc = 0;

        assign bus.iEN            = en;
        assign bus.iSTART         = start && (sel == 2'(g));
        assign bus.iFPA_OPERATION = op;
        assign bus.iIN_VALID      = in_valid && (sel == 2'(g));
        assign bus.iIN_DATA       = in_data;
        assign bus.iOUT_READY     = out_ready;
        assign bus.iADD_VALID     = s2_v;
        assign bus.iADD_RESULT    = s2_r;
        assign bus.iADD_OVERFLOW  = s2_v && ovf_inject && (rc == 1);
        assign bus.iADD_UNDERFLOW = 1'b0;
        assign bus.iADD_EXCEPTION = 1'b0;

        fpa_reduce_sched #(.DATA_WIDTH(DW), .N(NN)) u_dut (
            .iCLK    (clk),
            .iNRESET (rst_n),
            .bus     (bus.slave)
        );

        // External add unit: fixed latency of two cycles, never stalls.
        always @(posedge clk) begin
            s1_v <= bus.oADD_VALID;
            s1_r <= fadd(bus.oADD_A, bus.oADD_B);
            s2_v <= s1_v;
            s2_r <= s1_r;
            if (bus.iSTART) rc <= 0;
            else if (s2_v)  rc <= rc + 1;
        end

        assign in_ready_v[g]  = bus.oIN_READY;
        assign add_valid_v[g] = bus.oADD_VALID;
        assign out_valid_v[g] = bus.oOUT_VALID;
        assign busy_v[g]      = bus.oBUSY;
        assign ovf_v[g]       = bus.oFPA_OVERFLOW;
        assign unf_v[g]       = bus.oFPA_UNDERFLOW;
        assign exc_v[g]       = bus.oFPA_EXCEPTION;
        assign add_a_v[g]     = bus.oADD_A;
        assign add_b_v[g]     = bus.oADD_B;
        assign res_v[g]       = bus.oFPA_RESULT;
        assign add_op_v[g]    = bus.oADD_OPERATION;
    end

    always_comb begin
        sel_in_ready  = in_ready_v[sel];
        sel_add_valid = add_valid_v[sel];
        sel_out_valid = out_valid_v[sel];
        sel_busy      = busy_v[sel];
        sel_ovf       = ovf_v[sel];
        sel_unf       = unf_v[sel];
        sel_exc       = exc_v[sel];
        sel_add_a     = add_a_v[sel];
        sel_add_b     = add_b_v[sel];
        sel_res       = res_v[sel];
        sel_add_op    = add_op_v[sel];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the selected DUT issues or hands off a result.
    always @(negedge clk) begin
        if (int'(gen_dut[2].u_dut.count) > max_count) max_count = int'(gen_dut[2].u_dut.count);
        if (rst_n && sel_add_valid) begin
            issue_cnt++;
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL issue_unexpected: got A=%h B=%h, required no issue", sel_add_a, sel_add_b);
            end else begin
                checkOutput("issue_a", sel_add_a, exp_a_q.pop_front());
                checkOutput("issue_b", sel_add_b, exp_b_q.pop_front());
            end
        end
        if (rst_n && sel_out_valid && out_ready) begin
            if (exp_res_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL result_unexpected: got %h, required no result", sel_res);
            end else begin
                checkOutput("result", sel_res, exp_res_q.pop_front());
                checkOutput("flags", 32'({sel_ovf, sel_unf, sel_exc}), 32'(exp_flag_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1;
            if (en_toggle) en = ~en;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushPair(input logic [31:0] a, input logic [31:0] b);
        exp_a_q.push_back(a);
        exp_b_q.push_back(b);
    endtask

    task automatic pushResult(input logic [31:0] r, input logic [2:0] f);
        exp_res_q.push_back(r);
        exp_flag_q.push_back(f);
    endtask

    task automatic startJob(input logic [1:0] s, input logic [1:0] o);
        sel       = s;
        op        = o;
        issue_cnt = 0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int w;
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_data  = ops[i];
            w = 0;
            while (!sel_in_ready && w < 20) begin
                tick();
                w++;
            end
            if (!sel_in_ready) checkOutput("in_ready_timeout", 32'(sel_in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDone(input int limit);
        int w;
        w = 0;
        while (!sel_out_valid && w < limit) begin
            tick();
            w++;
        end
        checkOutput("done_reached", 32'(sel_out_valid), 32'd1);
    endtask

    task automatic finishJob();
        tick();
        checkOutput("idle_busy", 32'(sel_busy), 32'd0);
        checkOutput("idle_out_valid", 32'(sel_out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] mq [$];
        logic [31:0] a, b;
        en = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        out_ready = 1'b1; op = 2'b00; sel = 2'd0; ovf_inject = 1'b0; en_toggle = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(sel_busy), 32'd0);
        checkOutput("rst_in_ready", 32'(sel_in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(sel_out_valid), 32'd0);
        checkOutput("rst_add_valid", 32'(sel_add_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] job 1: N=4 sum 1+2+3+4");
        ops[0] = 32'h3F800000; ops[1] = 32'h40000000; ops[2] = 32'h40400000; ops[3] = 32'h40800000;
        pushPair(32'h3F800000, 32'h40000000);
        pushPair(32'h40400000, 32'h40800000);
        pushPair(32'h40400000, 32'h40E00000);
        pushResult(32'h41200000, 3'b000);
        startJob(2'd0, 2'b00);
        applyStimulus(4, 1'b0);
        waitDone(100);
        finishJob();
        checkOutput("n4_issue_count", 32'(issue_cnt), 32'd3);

        $display("[TB] job 2: N=1 passthrough");
        ops[0] = 32'h40490FDB;
        pushResult(32'h40490FDB, 3'b000);
        startJob(2'd1, 2'b11);
        applyStimulus(1, 1'b0);
        checkOutput("n1_done_next_cycle", 32'(sel_out_valid), 32'd1);
        waitDone(10);
        finishJob();
        checkOutput("n1_issue_count", 32'(issue_cnt), 32'd0);

        $display("[TB] job 3: N=16 with gaps and enable toggling");
        for (int i = 0; i < 16; i++) ops[i] = r2f(real'(i + 1));
        mq.delete();
        for (int i = 0; i < 16; i++) mq.push_back(ops[i]);
        while (mq.size() > 1) begin
            a = mq.pop_front();
            b = mq.pop_front();
            pushPair(a, b);
            mq.push_back(fadd(a, b));
        end
        pushResult(mq[0], 3'b000);
        max_count = 0;
        startJob(2'd2, 2'b00);
        en_toggle = 1'b1;
        applyStimulus(16, 1'b1);
        waitDone(2000);
        finishJob();
        en_toggle = 1'b0;
        en = 1'b1;
        checkOutput("n16_issue_count", 32'(issue_cnt), 32'd15);
        checkOutput("n16_count_bound", 32'(max_count <= 16), 32'd1);

        $display("[TB] job 4: overflow on 2nd result, consumer stalled");
        ops[0] = 32'h3FC00000; ops[1] = 32'h40200000; ops[2] = 32'hBF800000; ops[3] = 32'h3F000000;
        pushPair(32'h3FC00000, 32'h40200000);
        pushPair(32'hBF800000, 32'h3F000000);
        pushPair(32'h40800000, 32'hBF000000);
        pushResult(32'h40600000, 3'b100);
        ovf_inject = 1'b1;
        out_ready  = 1'b0;
        startJob(2'd0, 2'b01);
        applyStimulus(4, 1'b0);
        waitDone(100);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_out_valid", 32'(sel_out_valid), 32'd1);
            checkOutput("hold_result", sel_res, 32'h40600000);
            tick();
        end
        checkOutput("hold_add_op", 32'(sel_add_op), 32'd1);
        checkOutput("hold_flags", 32'({sel_ovf, sel_unf, sel_exc}), 32'd4);
        out_ready = 1'b1;
        finishJob();
        ovf_inject = 1'b0;

        $display("[TB] job 5: reset mid-reduce, then fresh job");
        ops[0] = 32'h3F800000; ops[1] = 32'h40000000; ops[2] = 32'h40400000; ops[3] = 32'h40800000;
        pushPair(32'h3F800000, 32'h40000000);
        pushPair(32'h40400000, 32'h40800000);
        pushPair(32'h40400000, 32'h40E00000);
        startJob(2'd0, 2'b10);
        applyStimulus(4, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("pre_reset_issues", 32'(issue_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(sel_busy), 32'd0);
        checkOutput("arst_add_valid", 32'(sel_add_valid), 32'd0);
        checkOutput("arst_add_a", sel_add_a, 32'd0);
        checkOutput("arst_add_b", sel_add_b, 32'd0);
        checkOutput("arst_add_op", 32'(sel_add_op), 32'd0);
        checkOutput("arst_in_ready", 32'(sel_in_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        exp_a_q.delete();
        exp_b_q.delete();
        exp_res_q.delete();
        exp_flag_q.delete();
        ops[0] = 32'h40000000; ops[1] = 32'h40800000; ops[2] = 32'h40C00000; ops[3] = 32'h41000000;
        pushPair(32'h40000000, 32'h40800000);
        pushPair(32'h40C00000, 32'h41000000);
        pushPair(32'h40C00000, 32'h41600000);
        pushResult(32'h41A00000, 3'b000);
        startJob(2'd0, 2'b00);
        applyStimulus(4, 1'b0);
        waitDone(100);
        finishJob();
        checkOutput("post_reset_issue_count", 32'(issue_cnt), 32'd3);
        checkOutput("scoreboard_drained", 32'(exp_a_q.size() + exp_res_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
